// File: rtl/ula_serial_resp.sv
// Bit-serial ULA responder for the control unit's ena_ula / ula_ack handshake.
// Optional signed-overflow output enabled by defining ULA_SERIAL_OVF_EN.
module ula_serial_resp #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena_ula,
    input  logic [1:0]       ula_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             ula_ack,
    output logic             busy
`ifdef ULA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   wres_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               c_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               zero_q;
`ifdef ULA_SERIAL_OVF_EN
    logic               ovf_q;
`endif

    logic               a_bit;
    logic               b_bit;
    logic               res_bit;
    logic               c_d;
    logic               arith;
    logic               last_bit;
    logic [WIDTH-1:0]   wres_d;

    // One bit-slice of the datapath; SUB adds the inverted B with carry-in 1.
    always_comb begin
        a_bit    = a_q[0];
        b_bit    = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
        res_bit  = 1'b0;
        c_d      = 1'b0;
        arith    = (op_q == OP_ADD) || (op_q == OP_SUB);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
        case (op_q)
            OP_ADD, OP_SUB: begin
                res_bit = a_bit ^ b_bit ^ c_q;
                c_d     = (a_bit & b_bit) | (a_bit & c_q) | (b_bit & c_q);
            end
            OP_AND:  res_bit = a_bit & b_bit;
            OP_OR:   res_bit = a_bit | b_bit;
            default: res_bit = 1'b0;
        endcase
        wres_d = {res_bit, wres_q[WIDTH-1:1]};
    end

    // Handshake FSM and serial datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            wres_q   <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
`ifdef ULA_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ena_ula) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        op_q    <= op_e'(ula_op);
                        c_q     <= (ula_op == 2'b01);
                        cnt_q   <= '0;
                        wres_q  <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!ena_ula) begin
                        state_q <= ST_IDLE;
                    end else begin
                        wres_q <= wres_d;
                        a_q    <= {1'b0, a_q[WIDTH-1:1]};
                        b_q    <= {1'b0, b_q[WIDTH-1:1]};
                        c_q    <= c_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            result_q <= wres_d;
                            carry_q  <= arith & c_d;
                            zero_q   <= (wres_d == '0);
`ifdef ULA_SERIAL_OVF_EN
                            // Carry into MSB is c_q on the last slice.
                            ovf_q    <= arith & (c_q ^ c_d);
`endif
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_q <= ena_ula ? ST_HOLD : ST_IDLE;
                ST_HOLD: begin
                    if (!ena_ula) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result  = result_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign ula_ack = (state_q == ST_DONE);
    assign busy    = (state_q == ST_SHIFT);
`ifdef ULA_SERIAL_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_ula_serial_resp.sv
// Scoreboard bench for ula_serial_resp: directed ops, abort, hold, reset.
module tb_ula_serial_resp;

    localparam int unsigned WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             z;
        logic             o;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             ena_ula;
    logic [1:0]       ula_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             ula_ack;
    logic             busy;
`ifdef ULA_SERIAL_OVF_EN
    logic             ovf;
`endif

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic prev_ack = 1'b0;

    ula_serial_resp #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena_ula (ena_ula),
        .ula_op  (ula_op),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (result),
        .carry   (carry),
        .zero    (zero),
        .ula_ack (ula_ack),
        .busy    (busy)
`ifdef ULA_SERIAL_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected response.
    always @(negedge clk) begin
        if (rst && ula_ack) begin
            chk("ack_single_cycle", 32'(prev_ack), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("carry", 32'(carry), 32'(e.c));
                chk("zero", 32'(zero), 32'(e.z));
`ifdef ULA_SERIAL_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.o));
`endif
            end
        end
        prev_ack = rst & ula_ack;
    end

    // Issue one op, check ack latency, optionally hold request past ack.
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] r, input logic c, input logic z, input logic o,
                          input int hold);
        int cyc;
        ena_ula = 1'b1;
        ula_op  = op;
        op_a    = a;
        op_b    = b;
        sb.push_back('{r: r, c: c, z: z, o: o});
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                op_a   = ~a;
                op_b   = ~b;
                ula_op = op ^ 2'b01;
            end
            if (ula_ack) break;
        end
        chk("ack_latency", 32'(cyc), 32'(WIDTH + 1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_no_ack", 32'(ula_ack), 32'd0);
            chk("hold_not_busy", 32'(busy), 32'd0);
        end
        ena_ula = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        ena_ula = 1'b0;
        ula_op  = 2'b00;
        op_a    = '0;
        op_b    = '0;
        @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_ack", 32'(ula_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op(2'b00, 4'd7, 4'd9, 4'd0, 1'b1, 1'b1, 1'b0, 0);
        run_op(2'b01, 4'd5, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 0);
        run_op(2'b01, 4'd3, 4'd5, 4'd14, 1'b0, 1'b0, 1'b0, 0);
        run_op(2'b10, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 0);
        run_op(2'b11, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0, 0);

        // Abort after two shift cycles: no ack, result unchanged.
        ena_ula = 1'b1;
        ula_op  = 2'b00;
        op_a    = 4'd1;
        op_b    = 4'd1;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        ena_ula = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'hE);
        chk("abort_ack", 32'(ula_ack), 32'd0);
        @(negedge clk);

        run_op(2'b00, 4'd6, 4'd6, 4'd12, 1'b0, 1'b0, 1'b1, 5);
        run_op(2'b00, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of SHIFT.
        ena_ula = 1'b1;
        ula_op  = 2'b10;
        op_a    = 4'hF;
        op_b    = 4'hF;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        chk("midrst_carry", 32'(carry), 32'd0);
        chk("midrst_ack", 32'(ula_ack), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(2'b00, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 0);

`ifdef ULA_SERIAL_OVF_EN
        run_op(2'b00, 4'd7, 4'd1, 4'd8, 1'b0, 1'b0, 1'b1, 0);
        run_op(2'b01, 4'd8, 4'd1, 4'd7, 1'b1, 1'b0, 1'b1, 0);
        run_op(2'b00, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
